// File: rtl/ex_div_ctrl.sv
// EX-stage iterative radix-2 restoring divide sequencer with stall/flush control.
// Define DIV_SIGNED_EN to honour DivOp[1] (signed divide/remainder).
module ex_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              DivReq,
    input  logic [1:0]        DivOp,
    input  logic [DATA_W-1:0] DivIn0,
    input  logic [DATA_W-1:0] DivIn1,
    output logic              DivStall,
    output logic              DivDone,
    output logic [DATA_W-1:0] DivOut,
    output logic              DivZero
);

    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic [CW-1:0]     cnt;
    logic              op_rem;
    logic              neg_q;
    logic              neg_r;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

`ifdef DIV_SIGNED_EN
    assign a_neg = DivOp[1] & DivIn0[DATA_W-1];
    assign b_neg = DivOp[1] & DivIn1[DATA_W-1];
    assign a_mag = a_neg ? -DivIn0 : DivIn0;
    assign b_mag = b_neg ? -DivIn1 : DivIn1;
`else
    logic unused_sign;
    assign unused_sign = DivOp[1];
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign a_mag = DivIn0;
    assign b_mag = DivIn1;
`endif

    // One restoring step: the shifted partial remainder needs DATA_W+1 bits.
    logic [DATA_W:0]   r_sh;
    logic [DATA_W-1:0] diff;
    logic              no_borrow;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign r_sh      = {rem, quo[DATA_W-1]};
    assign no_borrow = r_sh >= {1'b0, dvsr};
    assign diff      = r_sh[DATA_W-1:0] - dvsr;
    assign rem_nx    = no_borrow ? diff : r_sh[DATA_W-1:0];
    assign quo_nx    = {quo[DATA_W-2:0], no_borrow};
    assign q_fix     = neg_q ? -quo_nx : quo_nx;
    assign r_fix     = neg_r ? -rem_nx : rem_nx;

    assign DivStall = ((state == IDLE) & DivReq & ~Flush) | (state == CALC);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            DivDone <= 1'b0;
            DivOut  <= '0;
            DivZero <= 1'b0;
        end else if (Flush) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            DivDone <= 1'b0;
            DivOut  <= '0;
            DivZero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    DivDone <= 1'b0;
                    if (DivReq) begin
                        dvsr   <= b_mag;
                        quo    <= a_mag;
                        rem    <= '0;
                        cnt    <= CW'(DATA_W);
                        op_rem <= DivOp[0];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (DivIn1 == '0) begin
                            state   <= DONE;
                            DivDone <= 1'b1;
                            DivZero <= 1'b1;
                            DivOut  <= DivOp[0] ? DivIn0 : '1;
                        end else begin
                            state   <= CALC;
                            DivZero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state   <= DONE;
                        DivDone <= 1'b1;
                        DivOut  <= op_rem ? r_fix : q_fix;
                    end
                end
                DONE: begin
                    // The instruction leaves ID/EX on this edge, so DivReq is not looked at.
                    if (!Stall) begin
                        state   <= IDLE;
                        DivDone <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    DivDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Iterative divide sequencer for the EX stage. It accepts a divide/remainder request from the ID/EX boundary and runs a radix-2 restoring divider for DATA_W cycles. During that time it holds the pipeline with a stall request, then presents the result for one advance cycle. It sits beside the single-cycle ALU; the EX output mux selects DivOut when DivDone is high. It honours the pipeline Stall and Flush controls.

## Interface
- DATA_W, 32, operand/result width; counter width is clog2(DATA_W)+1
- clk  in  1  clock, all state updates on rising edge
- reset_  in  1  asynchronous, active-low reset
- Stall  in  1  pipeline stall from the pipeline controller; freezes DONE hand-off
- Flush  in  1  pipeline flush; cancels any operation in progress
- DivReq  in  1  level request, held high while the divide instruction sits in ID/EX
- DivOp  in  2  bit0: 0=quotient, 1=remainder; bit1: 1=signed (honoured only with DIV_SIGNED_EN)
- DivIn0  in  DATA_W  dividend
- DivIn1  in  DATA_W  divisor
- DivStall  out  1  combinational stall request to the pipeline controller
- DivDone  out  1  result valid, one advance cycle
- DivOut  out  DATA_W  selected quotient or remainder
- DivZero  out  1  divisor was zero; valid with DivDone

## Operation
- States: IDLE, CALC, DONE.
- IDLE, DivReq=1, Flush=0:
  - latch operand magnitudes, result sign flags and DivOp
  - clear the remainder register; load the counter with DATA_W
  - go to CALC, or straight to DONE if DivIn1==0
- CALC, each cycle:
  - shift {rem,quo} left by 1 and trial-subtract the divisor from rem
  - if no borrow, keep the difference and set quo[0]=1
  - decrement the counter; at count 1, go to DONE
- DONE:
  - DivDone=1 and DivOut valid
  - if Stall=1, hold DONE
  - else go to IDLE; DivReq is ignored in this cycle, because the instruction leaves ID/EX on this edge
- DivStall = (IDLE & DivReq & !Flush) | CALC. It is low in DONE.
- Divide by zero:
  - quotient = all ones; remainder = dividend
  - DivZero=1; no CALC cycles
- Signed fix-up is applied to the registered result when entering DONE:
  - quotient is negated if the operand signs differ
  - remainder takes the dividend sign
  - MIN/-1 yields quotient 0x8000_0000 and remainder 0 (DATA_W=32), with no exception
- Flush in any state: next state is IDLE; DivDone is not asserted; latched data is discarded.
- Reset: state IDLE; DivStall=0, DivDone=0, DivOut=0, DivZero=0; all internal registers 0.

## Timing
- Request accepted at edge T0, when DivReq is sampled in IDLE.
- CALC occupies edges T1..T(DATA_W).
- DONE is visible in the cycle after edge T(DATA_W), giving a total of DATA_W+1 stall cycles before the advance cycle.
- Divide-by-zero: DONE in the cycle after T0, so 1 stall cycle.
- DivOut, DivZero and DivDone are registered outputs; DivStall is combinational from state, DivReq and Flush.
- Flush and DivReq in the same IDLE cycle: not accepted, DivStall=0.
- Flush has priority over Stall in DONE.
- Reset asserted mid-CALC: outputs go to reset values immediately and asynchronously.

## Configuration
- DIV_SIGNED_EN defined:
  - DivOp[1] selects signed division
  - magnitude conversion on entry and sign fix-up on exit are present
- DIV_SIGNED_EN undefined:
  - DivOp[1] is ignored and all operations are unsigned
  - the sign logic is not synthesised

## Test plan
- Unsigned quotient, DivIn0=100, DivIn1=7, DivOp=00:
  - DivStall high for 33 cycles
  - DivDone for 1 cycle with DivOut=14, DivZero=0
- Remainder, same operands, DivOp=01: DivOut=2.
- Divide by zero, DivIn0=0x1234, DivIn1=0, DivOp=00:
  - DivStall for 1 cycle, then DivDone
  - DivOut=0xFFFF_FFFF, DivZero=1
  - repeat with DivOp=01: DivOut=0x1234
- Signed (DIV_SIGNED_EN), DivOp=10/11, -7/2:
  - DivOut=0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1)
  - 0x8000_0000 / -1 gives quotient 0x8000_0000 and remainder 0
- Flush at the 10th CALC cycle:
  - next cycle IDLE, DivStall=0, DivDone never pulses
  - a new request afterwards completes normally with the correct result
- Stall held 3 cycles while in DONE:
  - DivDone and DivOut stay stable for 4 cycles, then IDLE
  - a reset_ pulse mid-CALC zeroes all outputs immediately
